// File: rtl/card_row_scanner.sv
// card_row_scanner: turns the VGA counters into sprite-ROM addresses for a
// single horizontal row of up to 16 card slots, then composites the ROM's
// returned pixel over the background two cycles later.
// Optional feature macro: SELECT_HIGHLIGHT_EN (outline around the selected card).
//
// Walker state | meaning
// -------------+--------------------------------------------------
// idle         | outside the row; nothing is addressed
// active       | col/slot track the pixel being sampled this cycle
module card_row_scanner #(
    parameter int          ROW_X0       = 64,
    parameter int          ROW_Y0       = 400,
    parameter int          SLOTS        = 16,
    parameter logic [11:0] BG_COLOR     = 12'h060,
    parameter logic [11:0] KEY_COLOR    = 12'hF0F,
    parameter logic [11:0] HILITE_COLOR = 12'hFF0
) (
    input  logic        clk_25MHz,
    input  logic        rst_n,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic        video_valid,
    input  logic        wr_en,
    input  logic [3:0]  wr_slot,
    input  logic [5:0]  wr_card,
    input  logic        clr,
    input  logic [3:0]  sel_slot,
    input  logic        sel_valid,
    output logic [5:0]  card_type,
    output logic [5:0]  pixel_x,
    output logic [5:0]  pixel_y,
    input  logic [11:0] card_pixel,
    output logic [11:0] rgb
);

    localparam logic [9:0] X0       = 10'(ROW_X0);
    localparam logic [9:0] Y0       = 10'(ROW_Y0);
    localparam logic [9:0] Y_END    = 10'(ROW_Y0 + 46);
    localparam logic [3:0] LAST_SLT = 4'(SLOTS - 1);
    localparam logic [5:0] LAST_COL = 6'd35;
    localparam logic [5:0] EMPTY    = 6'd63;

    logic [5:0]  slot_tbl_q [16];
    logic        act_q, act_d;
    logic [5:0]  col_q, col_d;
    logic [3:0]  slot_q, slot_d;

    logic [5:0]  code;
    logic [9:0]  v_off;
    logic        in_rows, in_card, border;

    logic [5:0]  card_type_q, pixel_x_q, pixel_y_q;
    logic        in_card1_q, border1_q, vv1_q;
    logic        in_card2_q, border2_q, vv2_q;
    logic [11:0] rgb_q, rgb_d;

    // Slot table: clear beats write; out-of-range slot indices are dropped.
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) slot_tbl_q[i] <= EMPTY;
        end else if (clr) begin
            for (int i = 0; i < 16; i++) slot_tbl_q[i] <= EMPTY;
        end else if (wr_en && (int'(wr_slot) < SLOTS)) begin
            slot_tbl_q[wr_slot] <= wr_card;
        end
    end

    // Walker state register: remembers the position of the last sampled pixel.
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            act_q  <= 1'b0;
            col_q  <= '0;
            slot_q <= '0;
        end else begin
            act_q  <= act_d;
            col_q  <= col_d;
            slot_q <= slot_d;
        end
    end

    // Walker next state: position of the pixel being sampled now. Counting
    // instead of dividing h_cnt means a jump in h_cnt only resyncs at ROW_X0.
    always_comb begin
        act_d  = 1'b0;
        col_d  = col_q;
        slot_d = slot_q;
        if (h_cnt == X0) begin
            act_d  = 1'b1;
            col_d  = '0;
            slot_d = '0;
        end else if (act_q) begin
            act_d = 1'b1;
            if (col_q == LAST_COL) begin
                if (slot_q == LAST_SLT) begin
                    act_d = 1'b0;
                end else begin
                    col_d  = '0;
                    slot_d = slot_q + 4'd1;
                end
            end else begin
                col_d = col_q + 6'd1;
            end
        end
    end

    // Walker outputs: in-card decode and selection outline for this pixel.
    always_comb begin
        code    = slot_tbl_q[slot_d];
        v_off   = v_cnt - Y0;
        in_rows = (v_cnt >= Y0) && (v_cnt < Y_END);
        in_card = act_d && (col_d < 6'd32) && in_rows && (code < 6'd54);
`ifdef SELECT_HIGHLIGHT_EN
        border  = sel_valid && (sel_slot == slot_d) && in_card &&
                  ((col_d == 6'd0) || (col_d == 6'd31) ||
                   (v_off[5:0] == 6'd0) || (v_off[5:0] == 6'd45));
`else
        border  = 1'b0;
`endif
    end

`ifndef SELECT_HIGHLIGHT_EN
    logic unused_sel;
    assign unused_sel = ^{sel_slot, sel_valid};
`endif
    logic unused_voff;
    assign unused_voff = ^v_off[9:6];

    // Stage 1: ROM address plus flags; zero address outside cards.
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            card_type_q <= '0;
            pixel_x_q   <= '0;
            pixel_y_q   <= '0;
            in_card1_q  <= 1'b0;
            border1_q   <= 1'b0;
            vv1_q       <= 1'b0;
        end else begin
            card_type_q <= in_card ? code        : 6'd0;
            pixel_x_q   <= in_card ? col_d       : 6'd0;
            pixel_y_q   <= in_card ? v_off[5:0]  : 6'd0;
            in_card1_q  <= in_card;
            border1_q   <= border;
            vv1_q       <= video_valid;
        end
    end

    // Stage 2: flags delayed to line up with the ROM's returned pixel.
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            in_card2_q <= 1'b0;
            border2_q  <= 1'b0;
            vv2_q      <= 1'b0;
            rgb_q      <= '0;
        end else begin
            in_card2_q <= in_card1_q;
            border2_q  <= border1_q;
            vv2_q      <= vv1_q;
            rgb_q      <= rgb_d;
        end
    end

    // Compositing: blanking, then outline, then opaque card pixel, then background.
    always_comb begin
        rgb_d = BG_COLOR;
        if (!vv2_q)
            rgb_d = 12'h000;
        else if (border2_q)
            rgb_d = HILITE_COLOR;
        else if (in_card2_q && (card_pixel != KEY_COLOR))
            rgb_d = card_pixel;
    end

    assign card_type = card_type_q;
    assign pixel_x   = pixel_x_q;
    assign pixel_y   = pixel_y_q;
    assign rgb       = rgb_q;

endmodule

// File: tb/tb_card_row_scanner.sv
// Directed bench for card_row_scanner with a behavioural one-cycle sprite ROM.
module tb_card_row_scanner;

`ifdef SELECT_HIGHLIGHT_EN
    localparam bit HL = 1'b1;
`else
    localparam bit HL = 1'b0;
`endif

    logic        clk_25MHz = 1'b0;
    logic        rst_n;
    logic [9:0]  h_cnt, v_cnt;
    logic        video_valid;
    logic        wr_en;
    logic [3:0]  wr_slot;
    logic [5:0]  wr_card;
    logic        clr;
    logic [3:0]  sel_slot;
    logic        sel_valid;
    logic [5:0]  card_type, pixel_x, pixel_y;
    logic [11:0] card_pixel;
    logic [11:0] rgb;
    logic        rom_key;

    int          passed = 0;
    int          total  = 0;
    int          tbl [16];

    card_row_scanner dut (
        .clk_25MHz  (clk_25MHz),
        .rst_n      (rst_n),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .video_valid(video_valid),
        .wr_en      (wr_en),
        .wr_slot    (wr_slot),
        .wr_card    (wr_card),
        .clr        (clr),
        .sel_slot   (sel_slot),
        .sel_valid  (sel_valid),
        .card_type  (card_type),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .card_pixel (card_pixel),
        .rgb        (rgb)
    );

    always #20 clk_25MHz = ~clk_25MHz;

    // Sprite ROM stand-in: pixel encodes low nibble of the code and the column.
    always @(posedge clk_25MHz)
        card_pixel <= rom_key ? 12'hF0F : {2'b00, card_type[3:0], pixel_x};

    task automatic chk(input string tag, input int h, input logic [11:0] o, input logic [11:0] e);
        total++;
        assert (o === e) passed++;
        else $error("FAIL %s h=%0d observed=%h expected=%h", tag, h, o, e);
    endtask

    task automatic tick();
        @(posedge clk_25MHz);
        #1;
    endtask

    task automatic wr(input int s, input int c);
        wr_en = 1'b1; wr_slot = 4'(s); wr_card = 6'(c);
        tick();
        wr_en = 1'b0;
        tbl[s] = c;
    endtask

    task automatic scan_line(input int v, input bit vv, input bit key, input int wr_h);
        logic [11:0] p1 = '0, p2 = '0, cur;
        for (int h = 60; h < 646; h++) begin
            int rel, sl, c, code, py;
            bit act, inc, bord;
            logic [5:0] cv, cc;
            h_cnt = 10'(h); v_cnt = 10'(v); video_valid = vv; rom_key = key;
            if (h == wr_h) begin wr_en = 1'b1; wr_slot = 4'd0; wr_card = 6'd9; end
            rel  = h - 64;
            act  = (h >= 64) && (h < 64 + 16 * 36);
            sl   = act ? rel / 36 : 0;
            c    = act ? rel % 36 : 0;
            code = tbl[sl];
            py   = v - 400;
            inc  = act && (c < 32) && (v >= 400) && (v < 446) && (code < 54);
            bord = HL && sel_valid && (int'(sel_slot) == sl) && inc &&
                   (c == 0 || c == 31 || py == 0 || py == 45);
            cv = 6'(code); cc = 6'(c);
            tick();
            wr_en = 1'b0;
            if (h == wr_h) tbl[0] = 9;
            chk("card_type", h, 12'(card_type), inc ? 12'(cv) : 12'h0);
            chk("pixel_x",   h, 12'(pixel_x),   inc ? 12'(cc) : 12'h0);
            chk("pixel_y",   h, 12'(pixel_y),   inc ? 12'(py) : 12'h0);
            if (!vv)                cur = 12'h000;
            else if (bord)          cur = 12'hFF0;
            else if (inc && !key)   cur = {2'b00, cv[3:0], cc};
            else                    cur = 12'h060;
            if (h >= 62) chk("rgb", h - 2, rgb, p2);
            p2 = p1; p1 = cur;
        end
        h_cnt = 10'd0;
        tick(); tick();
    endtask

    initial begin
        rst_n = 1'b0; h_cnt = '0; v_cnt = '0; video_valid = 1'b0;
        wr_en = 1'b0; wr_slot = '0; wr_card = '0; clr = 1'b0;
        sel_slot = '0; sel_valid = 1'b0; rom_key = 1'b0;
        for (int i = 0; i < 16; i++) tbl[i] = 63;

        #50;
        chk("rst_card_type", 0, 12'(card_type), 12'h0);
        chk("rst_pixel_x",   0, 12'(pixel_x),   12'h0);
        chk("rst_pixel_y",   0, 12'(pixel_y),   12'h0);
        chk("rst_rgb",       0, rgb,            12'h0);
        rst_n = 1'b1;
        tick();

        // Mid-frame reset: populate a slot, scan into it, then pull reset.
        wr(0, 5);
        for (int h = 60; h < 75; h++) begin
            h_cnt = 10'(h); v_cnt = 10'd410; video_valid = 1'b1;
            tick();
        end
        #5 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) tbl[i] = 63;
        chk("midrst_card_type", 75, 12'(card_type), 12'h0);
        chk("midrst_pixel_x",   75, 12'(pixel_x),   12'h0);
        chk("midrst_pixel_y",   75, 12'(pixel_y),   12'h0);
        chk("midrst_rgb",       75, rgb,            12'h0);
        #5 rst_n = 1'b1;
        h_cnt = 10'd0;
        tick();
        scan_line(410, 1'b1, 1'b0, -1);

        wr(0, 5);
        wr(1, 52);
        wr(2, 60);
        wr(3, 0);
        wr(15, 53);
        scan_line(410, 1'b1, 1'b0, -1);

        sel_slot = 4'd1; sel_valid = 1'b1;
        scan_line(400, 1'b1, 1'b0, -1);
        sel_slot = 4'd15;
        scan_line(445, 1'b1, 1'b1, -1);
        sel_valid = 1'b0;
        scan_line(446, 1'b1, 1'b0, -1);
        scan_line(420, 1'b0, 1'b0, -1);
        scan_line(410, 1'b1, 1'b0, 80);

        clr = 1'b1; wr_en = 1'b1; wr_slot = 4'd0; wr_card = 6'd7;
        tick();
        clr = 1'b0; wr_en = 1'b0;
        for (int i = 0; i < 16; i++) tbl[i] = 63;
        scan_line(410, 1'b1, 1'b0, -1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/card_row_scanner.md
# card_row_scanner

Upstream feeder for the card sprite ROM stage (`Mem_pixel`). It holds a table of up to 16 card slots laid out as one horizontal row on screen. From the VGA counters it generates `card_type`, `pixel_x` and `pixel_y` for the ROM stage, then takes the returned `card_pixel` and composites it over the background. Selected-card highlighting is optional. Pipeline flags are delayed to match the ROM stage's 1-cycle block-RAM latency.

## Interface
Parameters:
- `ROW_X0`, 64: screen x of slot 0, column 0.
- `ROW_Y0`, 400: screen y of card row 0.
- `SLOTS`, 16: number of slots, 1..16.
- `BG_COLOR`, 12'h060: background RGB.
- `KEY_COLOR`, 12'hF0F: transparent key in `card_pixel`.
- `HILITE_COLOR`, 12'hFF0: selection border RGB.

Ports (one clock; reset is asynchronous and active-low):
- `clk_25MHz`  in  1: pixel clock.
- `rst_n`  in  1: async active-low reset.
- `h_cnt`  in  10: current VGA column; advances by 1 per clock within a line.
- `v_cnt`  in  10: current VGA row.
- `video_valid`  in  1: active display region.
- `wr_en`  in  1: write one slot.
- `wr_slot`  in  4: slot index to write.
- `wr_card`  in  6: card code. 0..53 are cards; 54..63 mean empty.
- `clr`  in  1: set all slots to 63 (empty).
- `sel_slot`  in  4: selected slot.
- `sel_valid`  in  1: a selection exists.
- `card_type`  out  6: to ROM stage (registered).
- `pixel_x`  out  6: to ROM stage, 0..31 (registered).
- `pixel_y`  out  6: to ROM stage, 0..45 (registered).
- `card_pixel`  in  12: from ROM stage, 1 cycle after the address.
- `rgb`  out  12: final pixel (registered).

## Operation
- Slot table: 16×6-bit registers. `clr` has priority over `wr_en`. `wr_en` with `wr_slot >= SLOTS` is ignored. Writes become visible to the scan on the next cycle.
- Horizontal walker: a column counter `col` (0..35) and a slot counter `slot` (0..SLOTS-1).
  - Both load 0 when sampled `h_cnt == ROW_X0`.
  - Otherwise, while active, `col` increments and wraps 35→0 with `slot++`.
  - The walker goes idle after `slot == SLOTS-1, col == 35`.
  - No divider is used. A non-sequential `h_cnt` corrupts the walk only until the next `ROW_X0`.
- In-card condition: walker active, `col < 32`, `ROW_Y0 <= v_cnt < ROW_Y0+46`, and slot code < 54. Columns 32..35 are gap and show background.
- Stage 1 (registered):
  - When in-card: `card_type` = slot code, `pixel_x` = `col`, `pixel_y` = `v_cnt-ROW_Y0`.
  - Otherwise: all three = 0.
  - Also registers flags `in_card1`, `border1` and `vv1`.
- Stage 2: delays the flags to `in_card2`, `border2` and `vv2`, aligned with `card_pixel`.
- Output, priority order:
  1. `!vv2` → 0.
  2. Else `border2` → `HILITE_COLOR`.
  3. Else `in_card2 && card_pixel != KEY_COLOR` → `card_pixel`.
  4. Else `BG_COLOR`.

## Timing
- Inputs sampled at edge N produce `card_type`/`pixel_x`/`pixel_y` after edge N and `rgb` after edge N+2. Fixed latency of 2 cycles.
- Reset (async, any time):
  - All slots = 63.
  - `card_type`, `pixel_x`, `pixel_y` and `rgb` = 0.
  - All flags = 0, walker idle.
- On release, the first valid `rgb` appears 2 cycles after the first sampled `video_valid`.
- A write during the scan of the same slot changes that slot's code starting at the next pixel.
- `sel_slot >= SLOTS` never highlights.

## Configuration
- `SELECT_HIGHLIGHT_EN` defined:
  - `border1` = `sel_valid`, slot == `sel_slot`, in-card, and (`col` ∈ {0,31} or `pixel_y` ∈ {0,45}).
  - Highlighting applies even to empty slots' outline area? No: only when the slot code < 54.
- Not defined: `border1` is tied to 0, and `sel_slot`/`sel_valid` are unused.

## Test plan
- Reset mid-frame:
  - Stimulus: assert `rst_n`=0 while scanning.
  - Required response: all outputs become 0 immediately. After release, an empty table gives `rgb` = 12'h060 across the row.
- Single card:
  - Stimulus: write slot 0 = 5; scan `v_cnt`=410, `h_cnt`=64..99.
  - Required response: `card_type`=5, `pixel_x`=0..31, `pixel_y`=10. `rgb` equals `card_pixel` 2 cycles later. Columns 96..99 give 12'h060.
- Slot wrap:
  - Stimulus: slot 1 = 52; `h_cnt`=100.
  - Required response: `card_type`=52, `pixel_x`=0. At `h_cnt`=64+16×36 the walker is idle and outputs are 0.
- Transparency and empty:
  - Stimulus: `card_pixel`=12'hF0F inside a card; slot code 60.
  - Required response: `rgb`=12'h060 in both cases; `card_type`=0 for the empty slot.
- Priority:
  - Stimulus: `clr` and `wr_en` in the same cycle.
  - Required response: every slot reads 63 afterwards.
- Highlight (macro on):
  - Stimulus: `sel_slot`=1, `sel_valid`=1, `v_cnt`=400.
  - Required response: `rgb`=12'hFF0 for `h_cnt` 100..131. With the macro off, the same pixels show `card_pixel`.
